// File: rtl/filter_pkg.sv
// Shared types, frame constants and channel quantization for the filter pipeline.
package filter_pkg;

  localparam int FRAME_W = 160;
  localparam int FRAME_H = 120;

  typedef enum logic [1:0] {IDLE, WRITE, DRAIN} fw_state_t;

  // Truncating quantization; result is right-aligned as {r, g, b}, each cbits wide.
  function automatic logic [23:0] quantize(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b, input int cbits);
    quantize = (({16'b0, r} >> (8 - cbits)) << (2 * cbits))
             | (({16'b0, g} >> (8 - cbits)) << cbits)
             |  ({16'b0, b} >> (8 - cbits));
  endfunction

endpackage

// File: rtl/frame_writer_if.sv
// Pixel stream in and framebuffer plot bus out; master is the frame writer side.
interface frame_writer_if #(
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int CBITS = 3
);
  logic [7:0]         red_in;
  logic [7:0]         green_in;
  logic [7:0]         blue_in;
  logic               in_valid;
  logic               in_ready;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [3*CBITS-1:0] colour;
  logic               plot_valid;
  logic               plot_ready;

  modport master (
    input  red_in, green_in, blue_in, in_valid, plot_ready,
    output in_ready, x, y, colour, plot_valid
  );

  modport slave (
    output red_in, green_in, blue_in, in_valid, plot_ready,
    input  in_ready, x, y, colour, plot_valid
  );
endinterface

// File: rtl/frame_writer_raster_counter.sv
// Raster-order px/py position counter with border and last-position flags.
module raster_counter #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int XW     = 8,
  parameter int YW     = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          en,
  output logic [XW-1:0] px,
  output logic [YW-1:0] py,
  output logic          is_border,
  output logic          is_last
);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      px <= '0;
      py <= '0;
    end else if (en) begin
      if (px == X_LAST) begin
        px <= '0;
        py <= (py == Y_LAST) ? '0 : py + 1'b1;
      end else begin
        px <= px + 1'b1;
      end
    end
  end

  assign is_border = (px == '0) || (px == X_LAST) || (py == '0) || (py == Y_LAST);
  assign is_last   = (px == X_LAST) && (py == Y_LAST);
endmodule

// File: rtl/frame_writer.sv
// Writes one full frame to the plot interface: interior pixels from the filter
// stream, one-pixel edge filled with a constant border colour.
//
// state | meaning
// IDLE  | waiting for start
// WRITE | loading positions (0,0)..(WIDTH-1,HEIGHT-1) into the plot register
// DRAIN | last write pending, waiting for plot_ready
module frame_writer
  import filter_pkg::*;
#(
  parameter int                   WIDTH         = FRAME_W,
  parameter int                   HEIGHT        = FRAME_H,
  parameter int                   XW            = 8,
  parameter int                   YW            = 7,
  parameter int                   CBITS         = 3,
  parameter logic [3*CBITS-1:0]   BORDER_COLOUR = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  frame_writer_if.master        fw
);
  localparam int CW = 3 * CBITS;

  fw_state_t       state, state_nxt;
  logic            slot_free;
  logic            load;
  logic            cnt_clear;
  logic            done_nxt;
  logic [XW-1:0]   px;
  logic [YW-1:0]   py;
  logic            is_border;
  logic            is_last;
  logic [CW-1:0]   q_colour;

  raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW)) u_raster (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (cnt_clear),
    .en        (load),
    .px        (px),
    .py        (py),
    .is_border (is_border),
    .is_last   (is_last)
  );

  assign slot_free = !fw.plot_valid || fw.plot_ready;
  assign q_colour  = CW'(quantize(fw.red_in, fw.green_in, fw.blue_in, CBITS));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_clear   = 1'b0;
    load        = 1'b0;
    fw.in_ready = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WRITE;
          cnt_clear = 1'b1;
        end
      end
      WRITE: begin
        fw.in_ready = slot_free && !is_border;
        load        = slot_free && (is_border || fw.in_valid);
        if (load && is_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (fw.plot_ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Plot register holds x/y/colour steady while the framebuffer stalls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fw.x          <= '0;
      fw.y          <= '0;
      fw.colour     <= '0;
      fw.plot_valid <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= done_nxt;
      if (load) begin
        fw.x          <= px;
        fw.y          <= py;
        fw.colour     <= is_border ? BORDER_COLOUR : q_colour;
        fw.plot_valid <= 1'b1;
      end else if (fw.plot_ready) begin
        fw.plot_valid <= 1'b0;
      end
    end
  end
endmodule
